// File: rtl/robot_brain.sv
// robot_brain: left-hand wall-following decision engine for the pipe-cleaning
// robot. One sensor snapshot in, one registered movement command out, with
// timed trash cleaning and stuck detection.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | no wall acquired yet; go straight until something is hit
// FOLLOW  | wall on the left; keep it there
// CLEAN   | CLEAN command issued; busy, snapshots dropped until timer ends
// HALT    | too many consecutive turns; answer NOP until reset
module robot_brain #(
  parameter int          CLEAN_CYCLES     = 8,
  parameter int          STUCK_LIMIT      = 4,
  parameter logic [1:0]  INIT_ORIENTATION = 2'b00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_valid,
  input  logic        head,
  input  logic        left,
  input  logic        trash_ahead,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [1:0]  orientation,
  output logic        busy,
  output logic        halted,
  output logic [15:0] move_count
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_FOLLOW = 2'd1;
  localparam logic [1:0] ST_CLEAN  = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_MOVE  = 3'b001;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_CLEAN = 3'b100;

  localparam logic [1:0] OR_N = 2'b00;
  localparam logic [1:0] OR_S = 2'b01;
  localparam logic [1:0] OR_E = 2'b10;
  localparam logic [1:0] OR_W = 2'b11;

  // Stuck counter only needs to reach STUCK_LIMIT; clean timer counts down
  // from CLEAN_CYCLES-1 to zero.
  localparam int STUCK_W = $clog2(STUCK_LIMIT + 1);
  localparam int CLEAN_W = (CLEAN_CYCLES > 1) ? $clog2(CLEAN_CYCLES) : 1;
  localparam logic [STUCK_W-1:0] STUCK_TC   = STUCK_W'(STUCK_LIMIT);
  localparam logic [CLEAN_W-1:0] CLEAN_LOAD = CLEAN_W'(CLEAN_CYCLES - 1);

  logic [1:0]         state_q;
  logic [1:0]         ret_state_q;
  logic [2:0]         prev_cmd_q;
  logic [STUCK_W-1:0] stuck_q;
  logic [CLEAN_W-1:0] clean_cnt_q;

  logic               accept;
  logic               follow_eff;
  logic               is_turn;
  logic [2:0]         dec_cmd;
  logic [1:0]         dec_state;
  logic [STUCK_W-1:0] stuck_next;
  logic [1:0]         orient_next;

  function automatic logic [1:0] rot_right(input logic [1:0] o);
    case (o)
      OR_N:    rot_right = OR_E;
      OR_E:    rot_right = OR_S;
      OR_S:    rot_right = OR_W;
      default: rot_right = OR_N;
    endcase
  endfunction

  function automatic logic [1:0] rot_left(input logic [1:0] o);
    case (o)
      OR_N:    rot_left = OR_W;
      OR_W:    rot_left = OR_S;
      OR_S:    rot_left = OR_E;
      default: rot_left = OR_N;
    endcase
  endfunction

  assign busy   = (state_q == ST_CLEAN);
  assign halted = (state_q == ST_HALT);
  assign accept = sensor_valid && !busy;

  // Decide the command, next state and stuck count for the current snapshot.
  always_comb begin
    dec_cmd    = CMD_NOP;
    dec_state  = state_q;
    follow_eff = (state_q == ST_FOLLOW) || ((state_q == ST_SEARCH) && left);
    if (state_q == ST_HALT) begin
      dec_cmd = CMD_NOP;
    end else if (trash_ahead) begin
      dec_cmd   = CMD_CLEAN;
      dec_state = ST_CLEAN;
    end else if (follow_eff) begin
      dec_state = ST_FOLLOW;
      // A single left turn is tried per gap; after it we go straight.
      if (!left && (prev_cmd_q != CMD_LEFT)) dec_cmd = CMD_LEFT;
      else if (head)                         dec_cmd = CMD_RIGHT;
      else                                   dec_cmd = CMD_MOVE;
    end else if (head) begin
      dec_cmd   = CMD_RIGHT;
      dec_state = ST_FOLLOW;
    end else begin
      dec_cmd = CMD_MOVE;
    end

    is_turn = (dec_cmd == CMD_RIGHT) || (dec_cmd == CMD_LEFT);
    if (is_turn)
      stuck_next = stuck_q + STUCK_W'(1);
    else if ((dec_cmd == CMD_MOVE) || (dec_cmd == CMD_CLEAN))
      stuck_next = '0;
    else
      stuck_next = stuck_q;
    if (is_turn && (stuck_next == STUCK_TC)) dec_state = ST_HALT;

    if (dec_cmd == CMD_RIGHT)     orient_next = rot_right(orientation);
    else if (dec_cmd == CMD_LEFT) orient_next = rot_left(orientation);
    else                          orient_next = orientation;
  end

  // State, clean timer and command registers; reset discards any clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEARCH;
      ret_state_q <= ST_SEARCH;
      prev_cmd_q  <= CMD_NOP;
      stuck_q     <= '0;
      clean_cnt_q <= '0;
      cmd         <= CMD_NOP;
      cmd_valid   <= 1'b0;
      orientation <= INIT_ORIENTATION;
      move_count  <= 16'h0000;
    end else begin
      cmd_valid <= accept;
      if (busy) begin
        if (clean_cnt_q == '0) begin
          state_q    <= ret_state_q;
        end else begin
          clean_cnt_q <= clean_cnt_q - CLEAN_W'(1);
        end
      end else if (accept) begin
        cmd         <= dec_cmd;
        prev_cmd_q  <= dec_cmd;
        state_q     <= dec_state;
        stuck_q     <= stuck_next;
        orientation <= orient_next;
        if (dec_cmd == CMD_CLEAN) begin
          ret_state_q <= state_q;
          clean_cnt_q <= CLEAN_LOAD;
        end
        if ((dec_cmd == CMD_MOVE) && (move_count != 16'hFFFF))
          move_count <= move_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_robot_brain.sv
// Directed bench for robot_brain: expected responses are queued as each
// snapshot is driven and compared when cmd_valid appears.
module tb_robot_brain;

  localparam logic [2:0] NOP = 3'b000, MOVE = 3'b001, TR = 3'b010,
                         TL = 3'b011, CLN = 3'b100;

  logic        clock;
  logic        reset;
  logic        sensor_valid;
  logic        head;
  logic        left;
  logic        trash_ahead;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [1:0]  orientation;
  logic        busy;
  logic        halted;
  logic [15:0] move_count;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [1:0]  ori;
    logic [15:0] mc;
    logic        busy;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   bcnt;

  robot_brain #(.CLEAN_CYCLES(8), .STUCK_LIMIT(4), .INIT_ORIENTATION(2'b00)) dut (
    .clock(clock), .reset(reset), .sensor_valid(sensor_valid), .head(head),
    .left(left), .trash_ahead(trash_ahead), .cmd(cmd), .cmd_valid(cmd_valid),
    .orientation(orientation), .busy(busy), .halted(halted), .move_count(move_count)
  );

  // 50 MHz clock
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one snapshot starting now (caller sits just after a negedge),
  // queue its expected response and compare when cmd_valid shows up.
  task automatic snap(input string tag, input logic h, input logic l, input logic t,
                      input logic [2:0] ec, input logic [1:0] eo, input logic [15:0] em,
                      input logic eb, input logic eh);
    exp_t e;
    exp_t got;
    bit   seen;
    head = h; left = l; trash_ahead = t; sensor_valid = 1'b1;
    q.push_back('{cmd: ec, ori: eo, mc: em, busy: eb, halted: eh});
    @(negedge clock);
    sensor_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (cmd_valid) seen = 1'b1;
      else @(negedge clock);
    end
    n_tests++;
    e = q.pop_front();
    if (!seen) begin
      n_fail++;
      $error("FAIL %s: no cmd_valid within 4 cycles, expected cmd %0h", tag, e.cmd);
    end else begin
      got = {cmd, orientation, move_count, busy, halted};
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s: observed cmd=%0h ori=%0h mc=%0h busy=%0b halt=%0b expected cmd=%0h ori=%0h mc=%0h busy=%0b halt=%0b",
               tag, cmd, orientation, move_count, busy, halted, e.cmd, e.ori, e.mc, e.busy, e.halted);
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; sensor_valid = 1'b0; head = 1'b0; left = 1'b0; trash_ahead = 1'b0;
    #1;
    chk("rst_cmd",       32'(cmd),         32'(NOP));
    chk("rst_cmd_valid", 32'(cmd_valid),   32'd0);
    chk("rst_ori",       32'(orientation), 32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_halted",    32'(halted),      32'd0);
    chk("rst_mc",        32'(move_count),  32'd0);
    @(negedge clock);
    reset = 1'b1;

    // open corridor from reset
    snap("first_move", 0, 0, 0, MOVE, 2'b00, 16'd1, 0, 0);

    // wall ahead, then single left turn into the gap, then straight
    pulse_reset();
    snap("search_tr",  1, 0, 0, TR,   2'b10, 16'd0, 0, 0);
    snap("follow_tl",  0, 0, 0, TL,   2'b00, 16'd0, 0, 0);
    snap("no_2nd_tl",  0, 0, 0, MOVE, 2'b00, 16'd1, 0, 0);

    // trash: busy for 8 cycles, snapshots inside dropped (incl. last busy cycle)
    snap("clean_cmd",  0, 0, 1, CLN,  2'b00, 16'd1, 1, 0);
    bcnt = 1;
    for (int i = 0; i < 20; i++) begin
      sensor_valid = (bcnt == 2 || bcnt == 8); head = 1'b0; left = 1'b0; trash_ahead = 1'b0;
      @(negedge clock);
      sensor_valid = 1'b0;
      chk("busy_drop", 32'(cmd_valid), 32'd0);
      if (busy) bcnt++;
      else break;
    end
    chk("busy_len", 32'(bcnt), 32'd8);
    // accepted on the first cycle busy is low; previous command was CLEAN
    snap("after_clean_tl", 0, 0, 0, TL, 2'b11, 16'd1, 0, 0);
    snap("follow_move",    0, 1, 0, MOVE, 2'b11, 16'd2, 0, 0);

    // boxed in: four right turns halt the robot
    snap("stuck_tr1", 1, 1, 0, TR, 2'b00, 16'd2, 0, 0);
    snap("stuck_tr2", 1, 1, 0, TR, 2'b10, 16'd2, 0, 0);
    snap("stuck_tr3", 1, 1, 0, TR, 2'b01, 16'd2, 0, 0);
    snap("stuck_tr4", 1, 1, 0, TR, 2'b11, 16'd2, 0, 1);
    snap("halt_nop",  1, 1, 0, NOP, 2'b11, 16'd2, 0, 1);
    snap("halt_trash", 0, 0, 1, NOP, 2'b11, 16'd2, 0, 1);

    // reset in the middle of a clean
    pulse_reset();
    snap("clean2", 0, 0, 1, CLN, 2'b00, 16'd0, 1, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy),        32'd0);
    chk("midrst_halted", 32'(halted),      32'd0);
    chk("midrst_ori",    32'(orientation), 32'd0);
    chk("midrst_valid",  32'(cmd_valid),   32'd0);
    @(negedge clock);
    reset = 1'b1;
    snap("midrst_move", 0, 0, 0, MOVE, 2'b00, 16'd1, 0, 0);

    // move_count saturation
    force dut.move_count = 16'hFFFE;
    #1;
    release dut.move_count;
    snap("sat_to_max", 0, 0, 0, MOVE, 2'b00, 16'hFFFF, 0, 0);
    snap("sat_hold",   0, 0, 0, MOVE, 2'b00, 16'hFFFF, 0, 0);

    // left wall acquired in SEARCH is followed on the same snapshot
    snap("search_left_move", 0, 1, 0, MOVE, 2'b00, 16'hFFFF, 0, 0);
    snap("acquired_tl",      0, 0, 0, TL,   2'b11, 16'hFFFF, 0, 0);
    snap("tl_then_tr",       1, 0, 0, TR,   2'b00, 16'hFFFF, 0, 0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
